// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one single-port, level-sensitive sram between two requesters:
//   m0 (instruction fetch) and m1 (load/store unit). Arbitration is
//   round-robin. Each access holds sram_cs for WAIT_CYCLES cycles.
//   The sram has no byte enables, so partial writes are done as
//   read-modify-write.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   mN_req                     request, held until mN_ack is sampled
//   mN_wr                      1 = write, 0 = read
//   mN_be                      byte enables (writes only)
//   mN_addr, mN_wdata          word address, write data
//   mN_ack                     one-cycle completion pulse
//   mN_rdata                   read data, held until that requester's next read
//   sram_cs, sram_wr           sram chip select / write strobe
//   sram_addr, sram_din        sram address / write data
//   sram_dout                  sram read data

module sram_arbiter #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_req,
    input  logic                    m0_wr,
    input  logic [DATA_WIDTH/8-1:0] m0_be,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic                    m0_ack,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    input  logic                    m1_req,
    input  logic                    m1_wr,
    input  logic [DATA_WIDTH/8-1:0] m1_be,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic                    m1_ack,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    sram_cs,
    output logic                    sram_wr,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_din,
    input  logic [DATA_WIDTH-1:0]   sram_dout
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;

    state_t                state, state_d;
    logic                  prio, prio_d;      // 0: m0 wins a tie, 1: m1 wins
    logic                  sel, sel_d;        // requester owning the current access
    logic                  rmw, rmw_d;
    logic [BE_W-1:0]       be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt, cnt_d;

    logic                  cs_d, wr_d, ack0_d, ack1_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] din_d, rdata0_d, rdata1_d;

    logic                  any_req, gnt;
    logic                  g_wr;
    logic [BE_W-1:0]       g_be;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic [DATA_WIDTH-1:0] merged;

    // A tie goes to the requester the pointer favours; a lone request
    // simply wins.
    assign any_req = m0_req | m1_req;
    assign gnt     = (m0_req && m1_req) ? prio : m1_req;
    assign g_wr    = gnt ? m1_wr    : m0_wr;
    assign g_be    = gnt ? m1_be    : m0_be;
    assign g_addr  = gnt ? m1_addr  : m0_addr;
    assign g_wdata = gnt ? m1_wdata : m0_wdata;

    // Byte merge for read-modify-write: enabled bytes come from the
    // requester and the rest from the word just read.
    always_comb begin
        merged = sram_dout;
        for (int i = 0; i < BE_W; i++) begin
            if (be_q[i]) begin
                merged[i*8 +: 8] = wdata_q[i*8 +: 8];
            end
        end
    end

    // Next-state logic. Every output is registered, so this block computes
    // next values for the output registers as well. sram_addr and sram_din
    // are only updated while cs is low or on the edge where cs rises, so the
    // level-sensitive sram never sees a moving address or data under a write.
    always_comb begin
        state_d  = state;
        prio_d   = prio;
        sel_d    = sel;
        rmw_d    = rmw;
        be_d     = be_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt;
        cs_d     = sram_cs;
        wr_d     = sram_wr;
        addr_d   = sram_addr;
        din_d    = sram_din;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = m0_rdata;
        rdata1_d = m1_rdata;

        case (state)
            IDLE: begin
                if (any_req) begin
                    sel_d   = gnt;
                    prio_d  = ~gnt;
                    rmw_d   = 1'b0;
                    be_d    = g_be;
                    wdata_d = g_wdata;
                    addr_d  = g_addr;
                    cnt_d   = '0;
                    if (!g_wr) begin
                        state_d = RD;
                        cs_d    = 1'b1;
                        wr_d    = 1'b0;
                    end else if (&g_be) begin
                        state_d = WR;
                        cs_d    = 1'b1;
                        wr_d    = 1'b1;
                        din_d   = g_wdata;
                    end else if (g_be == '0) begin
                        // Nothing to write: complete without touching the sram.
                        state_d = RESP;
                        ack0_d  = ~gnt;
                        ack1_d  = gnt;
                    end else begin
                        state_d = RD;
                        cs_d    = 1'b1;
                        wr_d    = 1'b0;
                        rmw_d   = 1'b1;
                    end
                end
            end

            RD: begin
                if (cnt == CNT_LAST) begin
                    cs_d  = 1'b0;
                    cnt_d = '0;
                    if (rmw) begin
                        din_d   = merged;
                        state_d = MERGE;
                    end else begin
                        if (sel) begin
                            rdata1_d = sram_dout;
                        end else begin
                            rdata0_d = sram_dout;
                        end
                        ack0_d  = ~sel;
                        ack1_d  = sel;
                        state_d = RESP;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            // One cycle with cs low so the merged word is settled before
            // the write strobe goes up.
            MERGE: begin
                state_d = WR;
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                cnt_d   = '0;
            end

            WR: begin
                if (cnt == CNT_LAST) begin
                    cs_d    = 1'b0;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    ack0_d  = ~sel;
                    ack1_d  = sel;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset drops cs/wr at once and abandons
    // any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio      <= 1'b0;
            sel       <= 1'b0;
            rmw       <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            sram_cs   <= 1'b0;
            sram_wr   <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            state     <= state_d;
            prio      <= prio_d;
            sel       <= sel_d;
            rmw       <= rmw_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            cnt       <= cnt_d;
            sram_cs   <= cs_d;
            sram_wr   <= wr_d;
            sram_addr <= addr_d;
            sram_din  <= din_d;
            m0_ack    <= ack0_d;
            m1_ack    <= ack1_d;
            m0_rdata  <= rdata0_d;
            m1_rdata  <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Directed bench for sram_arbiter with WAIT_CYCLES = 2. A simple sram
//   model (write on a clock edge while cs and wr are high, combinational
//   read) sits on the sram port. Expected values are hand-computed.

module tb_sram_arbiter;

    localparam int W = 2;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_wr, m0_ack;
    logic [3:0]  m0_be;
    logic [9:0]  m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_wr, m1_ack;
    logic [3:0]  m1_be;
    logic [9:0]  m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic        sram_cs, sram_wr;
    logic [9:0]  sram_addr;
    logic [31:0] sram_din, sram_dout;

    logic [31:0] mem [0:1023];
    logic        preloadDone = 1'b0;

    int assertCount = 0;
    int failCount   = 0;

    int overlapCount  = 0;
    int wrNoCsCount   = 0;
    int unstableCount = 0;
    int csCycles      = 0;
    int wrCycles      = 0;
    logic        prevCs = 1'b0;
    logic        prevWr = 1'b0;
    logic [9:0]  prevAddr = '0;
    logic [31:0] prevDin = '0;

    sram_arbiter #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (32),
        .WAIT_CYCLES(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req   (m0_req),
        .m0_wr    (m0_wr),
        .m0_be    (m0_be),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_wr    (m1_wr),
        .m1_be    (m1_be),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .sram_cs  (sram_cs),
        .sram_wr  (sram_wr),
        .sram_addr(sram_addr),
        .sram_din (sram_din),
        .sram_dout(sram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // sram model with a few preloaded words
    always @(posedge clk) begin
        if (!preloadDone) begin
            mem[10'h005] <= 32'hDEADBEEF;
            mem[10'h020] <= 32'h11223344;
            preloadDone  <= 1'b1;
        end else if (sram_cs && sram_wr) begin
            mem[sram_addr] <= sram_din;
        end
    end
    assign sram_dout = mem[sram_addr];

    // Mid-cycle protocol monitor: ack overlap, wr without cs, and
    // addr/din/wr moving while cs stays high.
    always @(negedge clk) begin
        if (m0_ack && m1_ack) overlapCount++;
        if (sram_wr && !sram_cs) wrNoCsCount++;
        if (prevCs && sram_cs &&
            (sram_addr != prevAddr || sram_din != prevDin || sram_wr != prevWr))
            unstableCount++;
        if (sram_cs) csCycles++;
        if (sram_cs && sram_wr) wrCycles++;
        prevCs   = sram_cs;
        prevWr   = sram_wr;
        prevAddr = sram_addr;
        prevDin  = sram_din;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int m, input logic wr, input logic [3:0] be,
                                 input logic [9:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            m0_wr = wr; m0_be = be; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
        end else begin
            m1_wr = wr; m1_be = be; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
        end
    endtask

    // Waits (bounded) for requester m's ack; latency counts edges after the
    // grant edge, which is the first edge after the call. Leaves the DUT in
    // its IDLE cycle on return.
    task automatic waitAck(input int m, input string tag, output int latency);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        latency = -1;
        while (!seen && n < 50) begin
            @(posedge clk);
            #1;
            n++;
            if ((m == 0) ? m0_ack : m1_ack) seen = 1'b1;
        end
        if (seen) latency = n - 1;
        if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, "_ack_pulse"}, {63'd0, (m == 0) ? m0_ack : m1_ack}, 64'd0);
    endtask

    int lat;
    int csBefore, wrBefore;
    int ackWho [0:5];
    int ackCyc [0:5];
    int nAck;

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m0_wr = 0; m0_be = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wr = 0; m1_be = 0; m1_addr = 0; m1_wdata = 0;

        #12;
        checkOutput("rst_cs_wr",   {62'd0, sram_cs, sram_wr}, 64'd0);
        checkOutput("rst_addr",    {54'd0, sram_addr}, 64'd0);
        checkOutput("rst_din",     {32'd0, sram_din}, 64'd0);
        checkOutput("rst_acks",    {62'd0, m0_ack, m1_ack}, 64'd0);
        checkOutput("rst_rdata",   {m0_rdata, m1_rdata}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // m0 read of a preloaded word
        csBefore = csCycles;
        applyStimulus(0, 1'b0, 4'h0, 10'h005, 32'h0);
        waitAck(0, "rd0", lat);
        checkOutput("rd0_latency", 64'(lat), 64'(W));
        checkOutput("rd0_rdata", {32'd0, m0_rdata}, 64'hDEADBEEF);
        checkOutput("rd0_m1_rdata", {32'd0, m1_rdata}, 64'd0);
        checkOutput("rd0_cs_cycles", 64'(csCycles - csBefore), 64'(W));

        // m1 full-word write, then m0 reads it back
        csBefore = csCycles;
        wrBefore = wrCycles;
        applyStimulus(1, 1'b1, 4'hF, 10'h010, 32'h12345678);
        waitAck(1, "wr1", lat);
        checkOutput("wr1_latency", 64'(lat), 64'(W));
        checkOutput("wr1_mem", {32'd0, mem[10'h010]}, 64'h12345678);
        checkOutput("wr1_cs_cycles", 64'(csCycles - csBefore), 64'(W));
        checkOutput("wr1_wr_cycles", 64'(wrCycles - wrBefore), 64'(W));
        applyStimulus(0, 1'b0, 4'h0, 10'h010, 32'h0);
        waitAck(0, "rd0b", lat);
        checkOutput("rd0b_latency", 64'(lat), 64'(W));
        checkOutput("rd0b_rdata", {32'd0, m0_rdata}, 64'h12345678);

        // m1 partial write: read-modify-write
        csBefore = csCycles;
        wrBefore = wrCycles;
        applyStimulus(1, 1'b1, 4'h3, 10'h020, 32'hAAAA5555);
        waitAck(1, "rmw1", lat);
        checkOutput("rmw1_latency", 64'(lat), 64'(2 * W + 1));
        checkOutput("rmw1_mem", {32'd0, mem[10'h020]}, 64'h11225555);
        checkOutput("rmw1_cs_cycles", 64'(csCycles - csBefore), 64'(2 * W));
        checkOutput("rmw1_wr_cycles", 64'(wrCycles - wrBefore), 64'(W));
        checkOutput("rmw1_m0_rdata", {32'd0, m0_rdata}, 64'h12345678);
        applyStimulus(1, 1'b0, 4'h0, 10'h020, 32'h0);
        waitAck(1, "rd1", lat);
        checkOutput("rd1_rdata", {32'd0, m1_rdata}, 64'h11225555);
        checkOutput("rd1_m0_rdata", {32'd0, m0_rdata}, 64'h12345678);

        // m1 write with no byte enables: immediate ack, no sram access
        csBefore = csCycles;
        applyStimulus(1, 1'b1, 4'h0, 10'h005, 32'h0);
        waitAck(1, "be0", lat);
        checkOutput("be0_latency", 64'(lat), 64'd0);
        checkOutput("be0_cs_cycles", 64'(csCycles - csBefore), 64'd0);
        checkOutput("be0_mem", {32'd0, mem[10'h005]}, 64'hDEADBEEF);

        // Reset in the middle of a write
        applyStimulus(0, 1'b1, 4'hF, 10'h030, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        checkOutput("mid_wr_cs", {62'd0, sram_cs, sram_wr}, 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_cs_wr", {62'd0, sram_cs, sram_wr}, 64'd0);
        m0_req = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("post_rst_no_ack", {62'd0, m0_ack, m1_ack}, 64'd0);
        end

        // Both requesters read continuously: grants must alternate from m0
        applyStimulus(0, 1'b0, 4'h0, 10'h005, 32'h0);
        applyStimulus(1, 1'b0, 4'h0, 10'h010, 32'h0);
        nAck = 0;
        for (int c = 0; c < 60 && nAck < 6; c++) begin
            @(posedge clk);
            #1;
            if (m0_ack || m1_ack) begin
                ackWho[nAck] = m1_ack ? 1 : 0;
                ackCyc[nAck] = c;
                nAck++;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        checkOutput("rr_ack_count", 64'(nAck), 64'd6);
        for (int k = 0; k < nAck; k++) begin
            checkOutput("rr_order", 64'(ackWho[k]), 64'(k % 2));
            if (k > 0)
                checkOutput("rr_spacing", 64'(ackCyc[k] - ackCyc[k-1]), 64'(W + 2));
        end
        checkOutput("rr_m0_rdata", {32'd0, m0_rdata}, 64'hDEADBEEF);
        checkOutput("rr_m1_rdata", {32'd0, m1_rdata}, 64'h12345678);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("ack_overlap", 64'(overlapCount), 64'd0);
        checkOutput("wr_without_cs", 64'(wrNoCsCount), 64'd0);
        checkOutput("bus_stable_under_cs", 64'(unstableCount), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one single-port `sram` instance between two requesters: m0 (instruction fetch) and m1 (load/store unit).
- Round-robin arbitration between the two.
- Sequences the level-sensitive sram control pins (`cs`, `wr`, `addr`, `din`) over a configurable number of clock cycles, and captures `dout`.
- Implements byte-enabled writes as read-modify-write, because the sram has no byte enables.

Parameters:
- ADDR_WIDTH, 10, word address width; matches the sram.
- DATA_WIDTH, 32, word width; must be a multiple of 8. BE_W = DATA_WIDTH/8.
- WAIT_CYCLES, 1, cycles `cs` is held per sram phase; must be ≥1 and cover the sram DELAY_TIME.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req / m1_req  in  1  request; held high until ack is sampled.
- m0_wr / m1_wr  in  1  1 = write, 0 = read.
- m0_be / m1_be  in  BE_W  byte enables; writes only.
- m0_addr / m1_addr  in  ADDR_WIDTH  word address.
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data.
- m0_ack / m1_ack  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  DATA_WIDTH  read data; valid with ack and held until that requester's next read completes.
- sram_cs  out  1  to sram `cs`.
- sram_wr  out  1  to sram `wr`.
- sram_addr  out  ADDR_WIDTH  to sram `addr`.
- sram_din  out  DATA_WIDTH  to sram `din`.
- sram_dout  in  DATA_WIDTH  from sram `dout`.

Behaviour:
- Reset (rst_n low, async): state IDLE, round-robin pointer favours m0. All outputs go to 0: sram_cs, sram_wr, sram_addr, sram_din, both acks, both rdata.
  - Reset mid-access drops sram_cs/sram_wr immediately; the access is abandoned and no ack is issued.
- All outputs are registered.
- sram_addr, sram_din and sram_wr change only on an edge where sram_cs is 0, or on the same edge where sram_cs rises.
  - This prevents spurious writes in the level-sensitive sram.
- States: IDLE, RD, MERGE, WR, RESP.
- IDLE:
  - Samples both reqs.
  - If both are high, grant the requester the pointer favours; the pointer then favours the other one.
  - If one is high, grant it; the pointer moves away from the granted requester.
  - At grant, latch wr/be/addr/wdata. Later changes on the requester's inputs are ignored until ack.
- Grant transitions:
  - Read → RD.
  - Write with be all-ones → WR, with din = wdata.
  - Write with be = 0 → RESP; no sram access.
  - Other writes → RD, flagged as read-modify-write (RMW).
- RD: sram_cs=1, sram_wr=0 for WAIT_CYCLES cycles. On the last edge, capture sram_dout and drop sram_cs.
  - Plain read: load the granted requester's rdata → RESP.
  - RMW: merge the captured word per byte (be[i] ? wdata byte : dout byte) into sram_din → MERGE.
- MERGE: one cycle with sram_cs=0 and merged din stable → WR.
- WR: sram_cs=1, sram_wr=1 for WAIT_CYCLES cycles. On the last edge, sram_cs=0 and sram_wr=0 → RESP.
- RESP: the granted requester's ack=1 for exactly one cycle; requests are not sampled → IDLE.
- Latency, with grant edge E0 and W = WAIT_CYCLES (ack is high during the cycle that begins at the listed edge):
  - Read or full write: ack at E0+W.
  - RMW: ack at E0+2W+1.
  - be=0 write: ack at E0.
- Back-to-back: a requester may keep req high past ack with new fields for its next transaction.
  - It is re-arbitrated in the IDLE cycle after RESP, so the minimum request spacing is W+2 cycles.
- Fairness: with both requesters continuously requesting, grants strictly alternate. No starvation.
- Only one ack is ever high per cycle. rdata of the non-granted requester never changes.

Test Plan:
- W=1, m0 read addr 0x005 (mem = 0xDEADBEEF) → sram_cs high 1 cycle, then m0_ack pulse with m0_rdata=0xDEADBEEF; m1 outputs unchanged.
- m1 write addr 0x010, be=0xF, wdata=0x12345678, then m0 read 0x010 → sram_wr high only while cs is high, din stable throughout, read returns 0x12345678.
- m1 write be=0x3, wdata=0xAAAA5555 to a word holding 0x11223344, W=2 → RD 2 cycles, MERGE 1 cycle, WR 2 cycles, ack 5 cycles after grant; readback 0x11225555.
- m0 and m1 request continuously from reset → grants m0, m1, m0, m1…; acks never overlap; each requester gets ≥1 ack per two transactions.
- Assert rst_n low while in WR of a write → sram_cs/sram_wr drop within the same cycle, no ack; after release, state IDLE and m0 wins the first tie.
- m1 write with be=0 → ack at the grant edge; sram_cs never asserted; memory unchanged.
